// File: rtl/rate_interpolator.sv
// Per-entry intensity/phase slew limiter.
// Each input beat targets the next entry of a DEPTH-entry frame. The stored value moves toward
// the target by at most the supplied rate; phase moves the short way around the circle.
// After reset the state memories are cleared one entry per cycle while BUSY is high.
// Pipeline: the beat is captured (stage 1), its entry is read, stepped and written back
// on the next edge (stage 2), and the result is registered onto the outputs one edge later.
// Because read, compute and write-back all sit in stage 1, a following beat to the same entry
// always reads the freshly written value, so no forwarding path is needed.

module rate_interpolator #(
    parameter int unsigned DEPTH = 249
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        DIN_VALID,
    input  logic [15:0] INTENSITY_IN,
    input  logic [15:0] PHASE_IN,
    input  logic [15:0] UPDATE_RATE_INTENSITY,
    input  logic [15:0] UPDATE_RATE_PHASE,
    output logic [15:0] INTENSITY_OUT,
    output logic [7:0]  PHASE_OUT,
    output logic        DOUT_VALID,
    output logic        BUSY
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);
    localparam logic [IdxW-1:0] OneIdx  = IdxW'(1);

    typedef enum logic [0:0] {
        StClear,
        StRun
    } state_e;

    // Control state
    state_e          state_q, state_d;
    logic [IdxW-1:0] clr_cnt_q, clr_cnt_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            busy_q;
    logic            beat_acc;

    // Stage 1: captured beat
    logic            s1_valid_q;
    logic [IdxW-1:0] s1_idx_q;
    logic [15:0]     s1_tint_q;
    logic [15:0]     s1_tph_q;
    logic [15:0]     s1_rint_q;
    logic [15:0]     s1_rph_q;

    // Stage 2: computed result
    logic            s2_valid_q;
    logic [15:0]     s2_int_q;
    logic [7:0]      s2_ph_q;

    // Output registers
    logic            dout_valid_q;
    logic [15:0]     int_out_q;
    logic [7:0]      ph_out_q;

    // State memories
    logic [15:0]     int_mem [DEPTH];
    logic [15:0]     ph_mem  [DEPTH];

    // Step datapath
    logic [15:0]     cur_int;
    logic [15:0]     cur_ph;
    logic [16:0]     int_up;
    logic [16:0]     int_dn;
    logic [15:0]     new_int;
    logic [15:0]     ph_fwd;
    logic [15:0]     ph_back;
    logic [15:0]     ph_step;
    logic [15:0]     new_ph;

    // Memory write port
    logic            mem_we;
    logic [IdxW-1:0] mem_waddr;
    logic [15:0]     mem_wint;
    logic [15:0]     mem_wph;

    assign beat_acc = (state_q == StRun) && DIN_VALID;

    // Next-state for the clear sequencer and the frame index
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        idx_d     = idx_q;
        unique case (state_q)
            StClear: begin
                clr_cnt_d = clr_cnt_q + OneIdx;
                if (clr_cnt_q == LastIdx) begin
                    state_d   = StRun;
                    clr_cnt_d = '0;
                    idx_d     = '0;
                end
            end
            StRun: begin
                if (DIN_VALID) begin
                    idx_d = (idx_q == LastIdx) ? '0 : idx_q + OneIdx;
                end
            end
            default: state_d = StClear;
        endcase
    end

    // Control registers; BUSY is registered from the next state
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            idx_q     <= idx_d;
            busy_q    <= (state_d == StClear);
        end
    end

    // Read the entry addressed by the beat in stage 1
    always_comb begin
        cur_int = int_mem[s1_idx_q];
        cur_ph  = ph_mem[s1_idx_q];
    end

    // Intensity: saturating step toward target using 17-bit sums so nothing wraps
    always_comb begin
        int_up = {1'b0, cur_int} + {1'b0, s1_rint_q};
        int_dn = {1'b0, cur_int} - {1'b0, s1_rint_q};
        if (cur_int < s1_tint_q) begin
            new_int = (int_up > {1'b0, s1_tint_q}) ? s1_tint_q : int_up[15:0];
        end else if (cur_int > s1_tint_q) begin
            // int_dn[16] is the borrow: the step went below zero, so clamp to target
            new_int = (int_dn[16] || (int_dn[15:0] < s1_tint_q)) ? s1_tint_q : int_dn[15:0];
        end else begin
            new_int = cur_int;
        end
    end

    // Phase: shortest-way step on the 2^16 circle; exact half turn goes backward
    always_comb begin
        ph_fwd  = s1_tph_q - cur_ph;
        ph_back = (~ph_fwd) + 16'd1;
        ph_step = '0;
        if (ph_fwd == 16'd0) begin
            new_ph = cur_ph;
        end else if (!ph_fwd[15]) begin
            ph_step = (s1_rph_q < ph_fwd) ? s1_rph_q : ph_fwd;
            new_ph  = cur_ph + ph_step;
        end else begin
            ph_step = (s1_rph_q < ph_back) ? s1_rph_q : ph_back;
            new_ph  = cur_ph - ph_step;
        end
    end

    // Single write port shared by the clear sequencer and the stage-1 write-back
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = s1_idx_q;
        mem_wint  = new_int;
        mem_wph   = new_ph;
        if (!RST) begin
            if (state_q == StClear) begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wint  = '0;
                mem_wph   = '0;
            end else if (s1_valid_q) begin
                mem_we = 1'b1;
            end
        end
    end

    // State memories; contents are defined by the clear sequence, not by reset
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            int_mem[mem_waddr] <= mem_wint;
            ph_mem[mem_waddr]  <= mem_wph;
        end
    end

    // Beat pipeline; reset drops any beat in flight
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid_q   <= 1'b0;
            s1_idx_q     <= '0;
            s1_tint_q    <= '0;
            s1_tph_q     <= '0;
            s1_rint_q    <= '0;
            s1_rph_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_int_q     <= '0;
            s2_ph_q      <= '0;
            dout_valid_q <= 1'b0;
            int_out_q    <= '0;
            ph_out_q     <= '0;
        end else begin
            s1_valid_q <= beat_acc;
            if (beat_acc) begin
                s1_idx_q  <= idx_q;
                s1_tint_q <= INTENSITY_IN;
                s1_tph_q  <= PHASE_IN;
                s1_rint_q <= UPDATE_RATE_INTENSITY;
                s1_rph_q  <= UPDATE_RATE_PHASE;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_int_q <= new_int;
                s2_ph_q  <= new_ph[15:8];
            end
            dout_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                int_out_q <= s2_int_q;
                ph_out_q  <= s2_ph_q;
            end
        end
    end

    assign INTENSITY_OUT = int_out_q;
    assign PHASE_OUT     = ph_out_q;
    assign DOUT_VALID    = dout_valid_q;
    assign BUSY          = busy_q;

endmodule

// File: tb/tb_rate_interpolator.sv
// Bench for rate_interpolator: a DEPTH=249 instance checked cycle by cycle against a
// frame-level reference model, and a DEPTH=1 instance driven from a directed vector table.

module tb_rate_interpolator;

    localparam int DEPTH = 249;
    localparam int NVEC  = 12;

    logic        clk;
    logic        rst;
    // Main instance
    logic        din_valid;
    logic [15:0] int_in, ph_in, rate_i, rate_p;
    logic [15:0] int_out;
    logic [7:0]  ph_out;
    logic        dout_valid, busy;
    // Single-entry instance
    logic        d1_valid;
    logic [15:0] d1_int_in, d1_ph_in, d1_rate_i, d1_rate_p;
    logic [15:0] d1_int_out;
    logic [7:0]  d1_ph_out;
    logic        d1_dout_valid, d1_busy;

    rate_interpolator #(.DEPTH(DEPTH)) u_dut (
        .CLK                   (clk),
        .RST                   (rst),
        .DIN_VALID             (din_valid),
        .INTENSITY_IN          (int_in),
        .PHASE_IN              (ph_in),
        .UPDATE_RATE_INTENSITY (rate_i),
        .UPDATE_RATE_PHASE     (rate_p),
        .INTENSITY_OUT         (int_out),
        .PHASE_OUT             (ph_out),
        .DOUT_VALID            (dout_valid),
        .BUSY                  (busy)
    );

    rate_interpolator #(.DEPTH(1)) u_dut1 (
        .CLK                   (clk),
        .RST                   (rst),
        .DIN_VALID             (d1_valid),
        .INTENSITY_IN          (d1_int_in),
        .PHASE_IN              (d1_ph_in),
        .UPDATE_RATE_INTENSITY (d1_rate_i),
        .UPDATE_RATE_PHASE     (d1_rate_p),
        .INTENSITY_OUT         (d1_int_out),
        .PHASE_OUT             (d1_ph_out),
        .DOUT_VALID            (d1_dout_valid),
        .BUSY                  (d1_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;

    // Reference model state
    typedef struct {
        int due;
        int ei;
        int ep;
    } exp_t;

    exp_t q[$];
    int   m_int [DEPTH];
    int   m_ph  [DEPTH];
    int   m_idx;
    int   m_clr_left;
    bit   m_run;
    int   hold_int;
    int   hold_ph;
    int   edge_no;

    typedef struct {
        logic [15:0] tint;
        logic [15:0] tph;
        logic [15:0] rint;
        logic [15:0] rph;
        logic [15:0] eint;
        logic [7:0]  eph;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s at edge %0d: got %0h, required %0h", name, edge_no, got, exp);
        end
    endtask

    function automatic int f_int(input int cur, input int tgt, input int rate);
        if (cur < tgt) return (cur + rate < tgt) ? cur + rate : tgt;
        if (cur > tgt) return (cur - rate > tgt) ? cur - rate : tgt;
        return cur;
    endfunction

    function automatic int f_ph(input int cur, input int tgt, input int rate);
        int d, back;
        d = (tgt - cur) & 'hFFFF;
        if (d == 0) return cur;
        if (d < 'h8000) return (cur + ((rate < d) ? rate : d)) & 'hFFFF;
        back = 65536 - d;
        return (cur - ((rate < back) ? rate : back)) & 'hFFFF;
    endfunction

    // One clock edge: advance the model with the inputs as sampled, then check the main DUT
    task automatic tick();
        bit   acc;
        int   ni, np;
        exp_t e;
        acc = !rst && m_run && din_valid;
        @(posedge clk);
        edge_no++;
        if (rst) begin
            q.delete();
            m_run      = 1'b0;
            m_clr_left = DEPTH;
            m_idx      = 0;
            hold_int   = 0;
            hold_ph    = 0;
        end else begin
            if (acc) begin
                ni = f_int(m_int[m_idx], int'(int_in), int'(rate_i));
                np = f_ph(m_ph[m_idx], int'(ph_in), int'(rate_p));
                m_int[m_idx] = ni;
                m_ph[m_idx]  = np;
                m_idx = (m_idx + 1) % DEPTH;
                e.due = edge_no + 2;
                e.ei  = ni;
                e.ep  = np;
                q.push_back(e);
            end
            if (!m_run) begin
                m_clr_left--;
                if (m_clr_left == 0) begin
                    m_run = 1'b1;
                    m_idx = 0;
                    for (int k = 0; k < DEPTH; k++) begin
                        m_int[k] = 0;
                        m_ph[k]  = 0;
                    end
                end
            end
        end
        #1;
        if (q.size() > 0 && q[0].due == edge_no) begin
            e = q.pop_front();
            check("dout_valid", 32'(dout_valid), 32'd1);
            check("intensity_out", 32'(int_out), e.ei);
            check("phase_out", 32'(ph_out), e.ep >> 8);
            hold_int = e.ei;
            hold_ph  = e.ep >> 8;
        end else begin
            check("dout_valid_idle", 32'(dout_valid), 32'd0);
            check("intensity_hold", 32'(int_out), hold_int);
            check("phase_hold", 32'(ph_out), hold_ph);
        end
        check("busy", 32'(busy), 32'(!m_run));
    endtask

    task automatic rand_inputs(input int gap_pct);
        int sel;
        din_valid = ($urandom_range(99) >= gap_pct);
        int_in    = 16'($urandom);
        ph_in     = 16'($urandom);
        sel = $urandom_range(3);
        rate_i = (sel == 0) ? 16'd0 : (sel == 1) ? 16'($urandom_range(1024))
               : (sel == 2) ? 16'($urandom) : 16'hFFFF;
        sel = $urandom_range(3);
        rate_p = (sel == 0) ? 16'd0 : (sel == 1) ? 16'($urandom_range(4096))
               : (sel == 2) ? 16'($urandom) : 16'hFFFF;
    endtask

    task automatic run_rand(input int cycles, input int gap_pct, input int rst_at);
        for (int c = 0; c < cycles; c++) begin
            rand_inputs(gap_pct);
            rst = (c == rst_at);
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        int n;
        // Directed single-entry vectors: every beat hits entry 0 back to back
        vecs[0]  = '{16'd1000, 16'hF000, 16'd300,  16'h0800, 16'd300,  8'hF8};
        vecs[1]  = '{16'd1000, 16'hF000, 16'd300,  16'h0800, 16'd600,  8'hF0};
        vecs[2]  = '{16'd1000, 16'hF000, 16'd300,  16'h0800, 16'd900,  8'hF0};
        vecs[3]  = '{16'd1000, 16'hF000, 16'd300,  16'h0800, 16'd1000, 8'hF0};
        vecs[4]  = '{16'd0,    16'h0000, 16'd600,  16'h1000, 16'd400,  8'h00};
        vecs[5]  = '{16'd0,    16'h8000, 16'd600,  16'h1000, 16'd0,    8'hF0};
        vecs[6]  = '{16'd0,    16'h0000, 16'd5,    16'hFFFF, 16'd0,    8'h00};
        vecs[7]  = '{16'hFFFF, 16'h7FFF, 16'hFFFF, 16'h1000, 16'hFFFF, 8'h10};
        vecs[8]  = '{16'hFFFF, 16'h2000, 16'h1234, 16'h0000, 16'hFFFF, 8'h10};
        vecs[9]  = '{16'h0000, 16'h0FFF, 16'h0000, 16'h7FFF, 16'hFFFF, 8'h0F};
        vecs[10] = '{16'h0001, 16'h8FFF, 16'hFFFF, 16'hFFFF, 16'h0001, 8'h8F};
        vecs[11] = '{16'hFFFE, 16'h0FFE, 16'hFFFF, 16'h7FFF, 16'hFFFE, 8'h0F};

        edge_no = 0;
        m_run = 1'b0;
        m_clr_left = DEPTH;
        m_idx = 0;
        hold_int = 0;
        hold_ph = 0;
        rst = 1'b1;
        din_valid = 1'b0;
        int_in = '0;
        ph_in = '0;
        rate_i = '0;
        rate_p = '0;
        d1_valid = 1'b0;
        d1_int_in = '0;
        d1_ph_in = '0;
        d1_rate_i = '0;
        d1_rate_p = '0;

        // Reset, then count BUSY cycles while offering beats that must be ignored
        tick();
        tick();
        rst = 1'b0;
        n = 0;
        while (n < 400) begin
            rand_inputs(0);
            tick();
            n++;
            if (busy !== 1'b1) break;
        end
        check("busy_cycles", 32'(n), 32'(DEPTH));
        din_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Single-entry table, applied back to back; result of beat i appears after edge i+2
        for (int i = 0; i < NVEC + 2; i++) begin
            if (i < NVEC) begin
                d1_valid  = 1'b1;
                d1_int_in = vecs[i].tint;
                d1_ph_in  = vecs[i].tph;
                d1_rate_i = vecs[i].rint;
                d1_rate_p = vecs[i].rph;
            end else begin
                d1_valid = 1'b0;
            end
            tick();
            if (i >= 2) begin
                check("d1_valid", 32'(d1_dout_valid), 32'd1);
                check("d1_intensity", 32'(d1_int_out), 32'(vecs[i-2].eint));
                check("d1_phase", 32'(d1_ph_out), 32'(vecs[i-2].eph));
            end
        end
        tick();
        check("d1_valid_after", 32'(d1_dout_valid), 32'd0);
        check("d1_intensity_held", 32'(d1_int_out), 32'(vecs[NVEC-1].eint));

        // Random frames against the model
        run_rand(2 * DEPTH, 0, -1);
        run_rand(2 * DEPTH, 25, -1);
        run_rand(700, 20, 300);
        run_rand(2 * DEPTH, 0, -1);
        din_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/rate_interpolator.md
RATE_INTERPOLATOR -- requirements
Module: rate_interpolator

Interface
REQ-001 SHALL have parameter DEPTH, default 249: number of transducer entries per frame.
REQ-002 SHALL have port CLK  input  1: sole clock; all logic on rising edge.
REQ-003 SHALL have port RST  input  1: reset, synchronous, active-high.
REQ-004 SHALL have port DIN_VALID  input  1: one entry beat, index implied by arrival order.
REQ-005 SHALL have port INTENSITY_IN  input  16: target intensity for the current entry.
REQ-006 SHALL have port PHASE_IN  input  16: target phase for the current entry, full circle = 2^16.
REQ-007 SHALL have port UPDATE_RATE_INTENSITY  input  16: max intensity step magnitude for this beat.
REQ-008 SHALL have port UPDATE_RATE_PHASE  input  16: max phase step magnitude for this beat.
REQ-009 SHALL have port INTENSITY_OUT  output  16: interpolated intensity for the entry.
REQ-010 SHALL have port PHASE_OUT  output  8: upper byte of interpolated phase for the entry.
REQ-011 SHALL have port DOUT_VALID  output  1: INTENSITY_OUT/PHASE_OUT valid this cycle.
REQ-012 SHALL have port BUSY  output  1: high while the state memory is being cleared; input ignored.

Function
REQ-013 SHALL hold per-entry state current_intensity[16] and current_phase[16] in DEPTH-deep memories.
REQ-014 SHALL have states CLEAR and RUN; RST forces CLEAR; CLEAR -> RUN after exactly DEPTH cycles.
REQ-015 In CLEAR, SHALL write 0 to entry k in the k-th cycle (k = 0..DEPTH-1), hold BUSY=1, ignore DIN_VALID.
REQ-016 In RUN, SHALL hold BUSY=0 and process every cycle with DIN_VALID=1 as one beat; gaps allowed.
REQ-017 SHALL keep index counter idx, 0 on leaving CLEAR, +1 per accepted beat, wrapping DEPTH-1 -> 0.
REQ-018 Intensity: cur < tgt -> new = min(cur + rate, tgt); cur > tgt -> new = max(cur - rate, tgt); equal -> hold.
REQ-019 Intensity arithmetic SHALL use 17-bit intermediates; no overflow, no overshoot past target.
REQ-020 Phase: d = (tgt - cur) mod 2^16; d = 0 -> hold.
REQ-021 Phase: d in [1, 0x7FFF] -> new = (cur + min(rate, d)) mod 2^16 (forward).
REQ-022 Phase: d in [0x8000, 0xFFFF] -> new = (cur - min(rate, 2^16 - d)) mod 2^16 (backward; tie 0x8000 goes backward).
REQ-023 Rate 0 SHALL hold the current value regardless of target.
REQ-024 SHALL write new values back to entry idx and present them on outputs; INTENSITY_OUT = new intensity, PHASE_OUT = new phase[15:8].
REQ-025 Latency SHALL be exactly 2 cycles: beat sampled at edge N -> DOUT_VALID=1 in the cycle after edge N+2.
REQ-026 DOUT_VALID SHALL be 1 for exactly one cycle per accepted beat, order preserved; outputs hold last values when DOUT_VALID=0.
REQ-027 Back-to-back beats to consecutive indices, including wrap DEPTH-1 -> 0 of a following frame, SHALL each read the value last written for that index (no stale reads).
REQ-028 DEPTH=1 SHALL be supported: consecutive beats hit the same entry; second beat SHALL see first beat's result.

Reset
REQ-029 On RST=1 at an edge: DOUT_VALID=0, INTENSITY_OUT=0, PHASE_OUT=0, BUSY=1, idx=0, state=CLEAR, in-flight beats discarded.
REQ-030 RST asserted mid-CLEAR or mid-frame SHALL restart CLEAR from entry 0; no DOUT_VALID until RUN and new beats.
REQ-031 After CLEAR completes, every entry SHALL read intensity 0, phase 0.

Verification
REQ-032 Reset, wait DEPTH cycles -> BUSY falls after exactly 249 cycles; DIN_VALID during BUSY produces no DOUT_VALID.
REQ-033 Entry 0: cur 0, tgt intensity 1000, rate 300, four frames -> INTENSITY_OUT 300, 600, 900, 1000; then tgt 0 rate 600 -> 400, 0.
REQ-034 Phase cur 0x0000, tgt 0xF000, rate 0x0800 -> backward: 0xF800 (PHASE_OUT 0xF8), then 0xF000 (0xF0), then hold.
REQ-035 Phase cur 0, tgt 0x8000, rate 0x1000 -> backward: PHASE_OUT 0xF0; tgt 0x7FFF, rate 0x1000 from 0 -> forward: 0x10.
REQ-036 Full frames of 249 back-to-back beats, random targets/rates, with DIN_VALID gaps and RST mid-frame -> output stream matches reference model per REQ-018..REQ-031, latency 2 on every beat.
